regfile_2r1w: RTL and testbench

- Parametrised register file: WIDTH x DEPTH storage, one synchronous write port, two independent read ports.
- Read ports are address-selected mux trees with a registered output stage and write-to-read bypass.
- Successor to the fixed 16:1 single-bit read mux. Generalised in data width, depth and port count; adds storage, read latency and forwarding.
- Sits between the decode stage (addresses) and the execute stage (operands) of the datapath.

---
 rtl/regfile_2r1w.sv | 119 +++++++++++
 tb/tb_regfile_2r1w.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// WIDTH x DEPTH register file with one write port and two registered read ports with write bypass.
// Optional: define REGFILE_ZERO_REG_EN to hardwire register DEPTH-1 to zero.
module regfile_2r1w #(
  parameter  int WIDTH  = 64,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              rd_valid
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Address splits into a low field (entry within group) and a high field (group).
  localparam int LO_W   = (ADDR_W > 1) ? ADDR_W / 2 : 1;
  localparam int HI_RAW = ADDR_W - LO_W;
  localparam int HI_W   = (HI_RAW > 0) ? HI_RAW : 1;
  localparam int GRP    = 1 << LO_W;
  localparam int NGRP   = 1 << HI_W;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZREG    = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_a;
  logic [WIDTH-1:0]  r_rd_b;
  logic              r_valid;

  logic              w_wr_ok;
  logic [DEPTH-1:0]  w_we;
  logic [WIDTH-1:0]  w_cell  [NGRP][GRP];
  logic [WIDTH-1:0]  w_grp_a [NGRP];
  logic [WIDTH-1:0]  w_grp_b [NGRP];
  logic [LO_W-1:0]   w_lo_a;
  logic [LO_W-1:0]   w_lo_b;
  logic [HI_W-1:0]   w_hi_a;
  logic [HI_W-1:0]   w_hi_b;
  logic [WIDTH-1:0]  w_mux_a;
  logic [WIDTH-1:0]  w_mux_b;
  logic              w_byp_a;
  logic              w_byp_b;

  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !(ZERO_REG && (wr_addr == ZREG));

  genvar gi, gk;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_wr_ok && (wr_addr == ADDR_W'(gi));
    end

    // Cells past DEPTH are tied to zero, which makes out-of-range reads return 0.
    for (gi = 0; gi < NGRP; gi++) begin : g_row
      for (gk = 0; gk < GRP; gk++) begin : g_col
        if (gi * GRP + gk < DEPTH) begin : g_live
          assign w_cell[gi][gk] = r_mem[gi * GRP + gk];
        end else begin : g_pad
          assign w_cell[gi][gk] = '0;
        end
      end
    end

    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      assign w_grp_a[gi] = w_cell[gi][w_lo_a];
      assign w_grp_b[gi] = w_cell[gi][w_lo_b];
    end
  endgenerate

  assign w_lo_a  = LO_W'(rd_addr_a);
  assign w_lo_b  = LO_W'(rd_addr_b);
  assign w_hi_a  = HI_W'(rd_addr_a >> LO_W);
  assign w_hi_b  = HI_W'(rd_addr_b >> LO_W);
  assign w_mux_a = w_grp_a[w_hi_a];
  assign w_mux_b = w_grp_b[w_hi_b];

  // w_wr_ok already excludes out-of-range and zero-register writes from forwarding.
  assign w_byp_a = w_wr_ok && (wr_addr == rd_addr_a);
  assign w_byp_b = w_wr_ok && (wr_addr == rd_addr_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) r_mem[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_en;
      if (rd_en) begin
        r_rd_a <= w_byp_a ? wr_data : w_mux_a;
        r_rd_b <= w_byp_b ? wr_data : w_mux_b;
      end
    end
  end

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign rd_valid  = r_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w at DEPTH=20 (non power of two, exercises out-of-range reads).
module tb_regfile_2r1w;
  localparam int W     = 64;
  localparam int DEPTH = 20;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic          rd_valid;

  regfile_2r1w #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         sb_q[$];
  logic [W-1:0] model [DEPTH];
  logic [W-1:0] hold_a = '0;
  logic [W-1:0] hold_b = '0;
  logic         exp_valid = 1'b0;

  function automatic bit is_store(input logic [AW-1:0] ad);
    if (int'(ad) >= DEPTH) return 1'b0;
`ifdef REGFILE_ZERO_REG_EN
    if (int'(ad) == DEPTH - 1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] model_rd(input logic we, input logic [AW-1:0] wa,
                                            input logic [W-1:0] wd, input logic [AW-1:0] ra);
    if (!is_store(ra)) return '0;
    if (we && wa == ra) return wd;
    return model[int'(ra)];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sb_q.delete();
    hold_a = '0;
    hold_b = '0;
    exp_valid = 1'b0;
  endtask

  // One clock of stimulus; predicts the output for the edge and advances to 1 unit after it.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
    if (re) begin
      e.a = model_rd(we, wa, wd, ra);
      e.b = model_rd(we, wa, wd, rb);
      sb_q.push_back(e);
      hold_a = e.a;
      hold_b = e.b;
    end
    exp_valid = re;
    if (we && is_store(wa)) model[int'(wa)] = wd;
    $display("txn t=%0t we=%0b wa=%0d wd=%h re=%0b ra=%0d rb=%0d", $time, we, wa, wd, re, ra, rb);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1'b1, AW'(3), 64'h1111_2222_3333_4444, 1'b0, '0, '0);
    drive(1'b1, AW'(5), 64'h5555_6666_7777_8888, 1'b1, AW'(3), AW'(5));
    e = sb_q.pop_front();
    n_checks += 3;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL pre_reset_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL pre_reset_b: got %h expected %h", rd_data_b, e.b); end
    if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL pre_reset_valid: got %b expected 1", rd_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_async_valid: got %b expected 0", rd_valid); end
    if (rd_data_a !== '0) begin n_errors++; $display("FAIL reset_async_a: got %h expected 0", rd_data_a); end
    if (rd_data_b !== '0) begin n_errors++; $display("FAIL reset_async_b: got %h expected 0", rd_data_b); end
    clear_model();
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_en = 1'b1; rd_addr_a = AW'(3); rd_addr_b = AW'(5);
    @(posedge clk);
    #1;
    n_checks += 2;
    if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hold_valid: got %b expected 0", rd_valid); end
    if (rd_data_a !== '0) begin n_errors++; $display("FAIL reset_hold_a: got %h expected 0", rd_data_a); end
    wr_en = 1'b0; rd_en = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(DEPTH - 1 - i));
      e = sb_q.pop_front();
      n_checks += 3;
      if (rd_data_a !== e.a) begin n_errors++; $display("FAIL post_reset_a[%0d]: got %h expected %h", i, rd_data_a, e.a); end
      if (rd_data_b !== e.b) begin n_errors++; $display("FAIL post_reset_b[%0d]: got %h expected %h", i, rd_data_b, e.b); end
      if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL post_reset_valid[%0d]: got %b expected 1", i, rd_valid); end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    drive(1'b1, AW'(5), 64'hDEADBEEF_CAFEF00D, 1'b0, '0, '0);
    n_checks++;
    if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL wr_only_valid: got %b expected 0", rd_valid); end
    drive(1'b0, '0, '0, 1'b1, AW'(5), AW'(0));
    e = sb_q.pop_front();
    n_checks += 3;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL wr_rd_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL wr_rd_b: got %h expected %h", rd_data_b, e.b); end
    if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL wr_rd_valid: got %b expected 1", rd_valid); end
  endtask

  task automatic test_hold();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      drive(k == 1, AW'(5), 64'h0000_0000_0000_0BAD, 1'b0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      n_checks += 3;
      if (rd_data_a !== hold_a) begin n_errors++; $display("FAIL hold_a[%0d]: got %h expected %h", k, rd_data_a, hold_a); end
      if (rd_data_b !== hold_b) begin n_errors++; $display("FAIL hold_b[%0d]: got %h expected %h", k, rd_data_b, hold_b); end
      if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL hold_valid[%0d]: got %b expected 0", k, rd_valid); end
    end
    drive(1'b0, '0, '0, 1'b1, AW'(5), AW'(5));
    e = sb_q.pop_front();
    n_checks++;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL hold_write_landed: got %h expected %h", rd_data_a, e.a); end
  endtask

  task automatic test_bypass();
    exp_t e;
    drive(1'b1, AW'(7), 64'hFFFF, 1'b0, '0, '0);
    drive(1'b1, AW'(7), 64'h1234, 1'b1, AW'(7), AW'(7));
    e = sb_q.pop_front();
    n_checks += 2;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL bypass_both_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL bypass_both_b: got %h expected %h", rd_data_b, e.b); end
    drive(1'b1, AW'(9), 64'hABCD, 1'b1, AW'(9), AW'(7));
    e = sb_q.pop_front();
    n_checks += 2;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL bypass_only_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL bypass_other_b: got %h expected %h", rd_data_b, e.b); end
    drive(1'b1, AW'(11), 64'h7777, 1'b1, AW'(9), AW'(11));
    e = sb_q.pop_front();
    n_checks += 2;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL bypass_other_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL bypass_only_b: got %h expected %h", rd_data_b, e.b); end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    drive(1'b1, AW'(DEPTH - 1), 64'hAAAA, 1'b1, AW'(DEPTH - 1), AW'(DEPTH - 1));
    e = sb_q.pop_front();
    n_checks += 2;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL top_reg_same_edge_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL top_reg_same_edge_b: got %h expected %h", rd_data_b, e.b); end
    drive(1'b0, '0, '0, 1'b1, AW'(DEPTH - 1), AW'(0));
    e = sb_q.pop_front();
    n_checks++;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL top_reg_reread: got %h expected %h", rd_data_a, e.a); end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    drive(1'b1, AW'(25), 64'h55, 1'b1, AW'(25), AW'(DEPTH));
    e = sb_q.pop_front();
    n_checks += 3;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL oor_bypass_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL oor_b: got %h expected %h", rd_data_b, e.b); end
    if (rd_valid !== 1'b1) begin n_errors++; $display("FAIL oor_valid: got %b expected 1", rd_valid); end
    drive(1'b0, '0, '0, 1'b1, AW'(25), AW'(31));
    e = sb_q.pop_front();
    n_checks += 2;
    if (rd_data_a !== e.a) begin n_errors++; $display("FAIL oor_reread_a: got %h expected %h", rd_data_a, e.a); end
    if (rd_data_b !== e.b) begin n_errors++; $display("FAIL oor_reread_b: got %h expected %h", rd_data_b, e.b); end
    for (int i = 0; i < DEPTH; i += 2) begin
      drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(i + 1));
      e = sb_q.pop_front();
      n_checks += 2;
      if (rd_data_a !== e.a) begin n_errors++; $display("FAIL oor_unchanged[%0d]: got %h expected %h", i, rd_data_a, e.a); end
      if (rd_data_b !== e.b) begin n_errors++; $display("FAIL oor_unchanged[%0d]: got %h expected %h", i + 1, rd_data_b, e.b); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 200; n++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      n_checks += 3;
      if (rd_valid !== exp_valid) begin n_errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", n, rd_valid, exp_valid); end
      if (exp_valid) begin
        e = sb_q.pop_front();
        if (rd_data_a !== e.a) begin n_errors++; $display("FAIL b2b_a[%0d]: got %h expected %h", n, rd_data_a, e.a); end
        if (rd_data_b !== e.b) begin n_errors++; $display("FAIL b2b_b[%0d]: got %h expected %h", n, rd_data_b, e.b); end
      end else begin
        if (rd_data_a !== hold_a) begin n_errors++; $display("FAIL b2b_hold_a[%0d]: got %h expected %h", n, rd_data_a, hold_a); end
        if (rd_data_b !== hold_b) begin n_errors++; $display("FAIL b2b_hold_b[%0d]: got %h expected %h", n, rd_data_b, hold_b); end
      end
    end
  endtask

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 3;
    if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL init_reset_valid: got %b expected 0", rd_valid); end
    if (rd_data_a !== '0) begin n_errors++; $display("FAIL init_reset_a: got %h expected 0", rd_data_a); end
    if (rd_data_b !== '0) begin n_errors++; $display("FAIL init_reset_b: got %h expected 0", rd_data_b); end
    reset_n = 1'b1;
    test_reset();
    test_write_read();
    test_hold();
    test_bypass();
    test_zero_reg();
    test_out_of_range();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
